// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and a level/pulse interrupt.
// Optional prescaler on CTRL[15:8] is built only when TIMER_PRESCALE_EN is defined.
module timer_dev (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PRESET = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;
   localparam logic [1:0] MODE_AUTO = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_CNT,
      S_INT
   } state_t;

   state_t      r_state, w_state_next;
   logic        r_en, w_en_next;
   logic [1:0]  r_mode, w_mode_next;
   logic        r_im, w_im_next;
   logic [31:0] r_preset, w_preset_next;
   logic [31:0] r_count, w_count_next;
   logic        r_pend, w_pend_next;
   logic        r_irq;

   logic        w_wr_ctrl;
   logic        w_wr_preset;
   logic        w_tick;
   logic [7:0]  w_psc_rd;

   assign w_wr_ctrl   = we && (addr == A_CTRL);
   assign w_wr_preset = we && (addr == A_PRESET);

`ifdef TIMER_PRESCALE_EN
   logic [7:0] r_psc, w_psc_next;
   logic [7:0] r_div, w_div_next;

   // A tick fires on the (P+1)-th CNT cycle; the divider idles at 0 outside CNT.
   assign w_tick   = (r_div == r_psc);
   assign w_psc_rd = r_psc;

   always_comb begin
      w_psc_next = r_psc;
      if (w_wr_ctrl) begin
         w_psc_next = din[15:8];
      end
   end

   always_comb begin
      w_div_next = 8'd0;
      if (!w_wr_ctrl && !w_wr_preset && (r_state == S_CNT) && !w_tick) begin
         w_div_next = r_div + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_psc <= 8'd0;
         r_div <= 8'd0;
      end else begin
         r_psc <= w_psc_next;
         r_div <= w_div_next;
      end
   end
`else
   assign w_tick   = 1'b1;
   assign w_psc_rd = 8'd0;
`endif

   always_comb begin
      w_state_next  = r_state;
      w_en_next     = r_en;
      w_mode_next   = r_mode;
      w_im_next     = r_im;
      w_preset_next = r_preset;
      w_count_next  = r_count;
      w_pend_next   = r_pend;

      if (w_wr_ctrl || w_wr_preset) begin
         // A CPU register write preempts whatever the FSM would do this edge.
         w_state_next = S_IDLE;
         w_pend_next  = 1'b0;
         if (w_wr_ctrl) begin
            w_en_next   = din[0];
            w_mode_next = din[2:1];
            w_im_next   = din[3];
         end else begin
            w_preset_next = din;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_en) begin
                  w_state_next = S_LOAD;
               end
            end
            S_LOAD: begin
               w_count_next = r_preset;
               w_state_next = S_CNT;
            end
            S_CNT: begin
               if (!r_en) begin
                  w_state_next = S_IDLE;
               end else if (w_tick) begin
                  if (r_count == 32'd0) begin
                     w_state_next = S_INT;
                     w_pend_next  = 1'b1;
                  end else begin
                     w_count_next = r_count - 32'd1;
                  end
               end
            end
            S_INT: begin
               if (r_mode == MODE_AUTO) begin
                  w_pend_next  = 1'b0;
                  w_state_next = S_LOAD;
               end else begin
                  w_en_next    = 1'b0;
                  w_state_next = S_IDLE;
               end
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_en     <= 1'b0;
         r_mode   <= 2'b00;
         r_im     <= 1'b0;
         r_preset <= 32'd0;
         r_count  <= 32'd0;
         r_pend   <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_en     <= w_en_next;
         r_mode   <= w_mode_next;
         r_im     <= w_im_next;
         r_preset <= w_preset_next;
         r_count  <= w_count_next;
         r_pend   <= w_pend_next;
         r_irq    <= w_im_next & w_pend_next;
      end
   end

   assign irq = r_irq;

   always_comb begin
      dout = 32'd0;
      case (addr)
         A_CTRL:   dout = {16'd0, w_psc_rd, 4'd0, r_im, r_mode, r_en};
         A_PRESET: dout = r_preset;
         A_COUNT:  dout = r_count;
         default:  dout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_timer_dev.sv
// Randomised and directed bench for timer_dev against a timeline-based reference model.
// Build with or without TIMER_PRESCALE_EN; the bench follows the same macro.
module tb_timer_dev;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  addr = 2'd0;
   logic        we = 1'b0;
   logic [31:0] din = 32'd0;
   logic [31:0] dout;
   logic        irq;

   int n_total = 0;
   int n_pass  = 0;
   bit cmp_on  = 1'b0;

   timer_dev dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .din   (din),
      .dout  (dout),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   // Model: a run restarts at a register write (or an auto-reload INT) and
   // m_k counts edges since then; COUNT and INT timing follow from m_k arithmetically.
   logic        m_en, m_im, m_pend;
   logic [1:0]  m_mode;
   logic [7:0]  m_psc;
   logic [31:0] m_preset, m_hold;
   longint      m_k;

   function automatic longint m_p();
`ifdef TIMER_PRESCALE_EN
      return longint'(m_psc);
`else
      return 0;
`endif
   endfunction

   function automatic logic [31:0] m_count();
      longint q;
      if (!m_en || m_k < 2) return m_hold;
      q = (m_k - 2) / (m_p() + 1);
      if (q > longint'(m_preset)) return 32'd0;
      return m_preset - 32'(q);
   endfunction

   function automatic logic [31:0] m_dout(input logic [1:0] a);
      case (a)
         2'd0: return {16'd0, m_p() != 0 ? m_psc : 8'd0, 4'd0, m_im, m_mode, m_en};
         2'd1: return m_preset;
         2'd2: return m_count();
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_step(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
      longint int_k;
      logic [31:0] cur;
      if (r) begin
         m_en = 0; m_im = 0; m_mode = 0; m_psc = 0; m_pend = 0;
         m_preset = 0; m_hold = 0; m_k = 0;
         return;
      end
      if (w && a <= 2'd1) begin
         cur = m_count();
         if (a == 2'd0) begin
            m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
`ifdef TIMER_PRESCALE_EN
            m_psc = d[15:8];
`endif
         end else begin
            m_preset = d;
         end
         m_pend = 0; m_hold = cur; m_k = 0;
         return;
      end
      if (!m_en) return;
      if (m_mode == 2'b01) m_pend = 0;
      int_k = 2 + (longint'(m_preset) + 1) * (m_p() + 1);
      m_k++;
      if (m_k == int_k) begin
         m_pend = 1;
         if (m_mode == 2'b01) begin
            m_k = 0; m_hold = 0;
         end
      end else if (m_k == int_k + 1) begin
         m_en = 0; m_hold = 0; m_k = 0;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
   endtask

   task automatic drive(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
      reset = r; we = w; addr = a; din = d;
      @(posedge clk);
      m_step(r, w, a, d);
      #1;
      we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      we = 1'b0; addr = a;
      #1;
      v = dout;
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("dout_model", dout, m_dout(addr));
         chk("irq_model", {31'd0, irq}, {31'd0, m_im & m_pend});
      end
   end

   initial begin
      logic [31:0] v;
      logic [31:0] d;
      int lat;

      drive(1, 0, 0, 0);
      cmp_on = 1'b1;
      drive(1, 1, 1, 32'h1234);
      drive(0, 0, 0, 0);
      $display("txn reset done");
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), v);
         chk("reset_read", v, 32'd0);
      end
      chk("reset_irq", {31'd0, irq}, 32'd0);

      // one-shot, PRESET=5: irq rises after E+8 and holds
      drive(0, 1, 1, 5);
      drive(0, 1, 0, 32'h9);
      $display("txn one-shot preset=5 ctrl=0x9");
      for (int i = 1; i <= 8; i++) begin
         drive(0, 0, 0, 0);
         chk("oneshot_irq", {31'd0, irq}, {31'd0, i == 8});
      end
      drive(0, 0, 0, 0);
      rd(0, v);
      chk("oneshot_ctrl", v, 32'h8);
      chk("oneshot_hold", {31'd0, irq}, 32'd1);
      drive(0, 1, 0, 0);
      chk("oneshot_clear", {31'd0, irq}, 32'd0);

      // auto-reload, PRESET=3: pulse every 6 cycles, COUNT 3,2,1,0
      drive(0, 1, 1, 3);
      drive(0, 1, 0, 32'hB);
      $display("txn auto-reload preset=3 ctrl=0xB");
      for (int i = 1; i <= 18; i++) begin
         drive(0, 0, 0, 0);
         chk("auto_irq", {31'd0, irq}, {31'd0, (i % 6) == 0});
         if ((i % 6) >= 2 && (i % 6) <= 5) begin
            rd(2, v);
            chk("auto_count", v, 32'(5 - (i % 6)));
         end
      end
      drive(0, 1, 0, 0);

      // restart: PRESET=10, rewrite PRESET=2 at COUNT=4
      drive(0, 1, 1, 10);
      drive(0, 1, 0, 32'h9);
      $display("txn restart preset=10 ctrl=0x9");
      for (int i = 1; i <= 8; i++) drive(0, 0, 0, 0);
      rd(2, v);
      chk("restart_count4", v, 32'd4);
      drive(0, 1, 1, 2);
      $display("txn restart preset=2");
      for (int i = 1; i <= 5; i++) begin
         drive(0, 0, 0, 0);
         chk("restart_irq", {31'd0, irq}, {31'd0, i == 5});
      end
      drive(0, 1, 0, 0);

      // PRESET=0 with IM=0: irq never rises, EN cleared after INT
      drive(0, 1, 1, 0);
      drive(0, 1, 0, 32'h1);
      $display("txn masked preset=0 ctrl=0x1");
      for (int i = 1; i <= 4; i++) begin
         drive(0, 0, 0, 0);
         chk("masked_irq", {31'd0, irq}, 32'd0);
      end
      rd(0, v);
      chk("masked_ctrl", v, 32'd0);
      drive(0, 1, 0, 32'h8);
      chk("masked_im_irq", {31'd0, irq}, 32'd0);
      drive(0, 0, 0, 0);
      chk("masked_im_irq2", {31'd0, irq}, 32'd0);

      // prescale field: PRESET=2, CTRL=0x0309
`ifdef TIMER_PRESCALE_EN
      lat = 14;
`else
      lat = 5;
`endif
      drive(0, 1, 1, 2);
      drive(0, 1, 0, 32'h0309);
      $display("txn prescale preset=2 ctrl=0x0309");
      for (int i = 1; i <= lat; i++) begin
         drive(0, 0, 0, 0);
         chk("psc_irq", {31'd0, irq}, {31'd0, i == lat});
      end
      drive(0, 0, 0, 0);
      rd(0, v);
`ifdef TIMER_PRESCALE_EN
      chk("psc_ctrl", v, 32'h0308);
`else
      chk("psc_ctrl", v, 32'h8);
`endif
      drive(0, 1, 0, 0);

      // reset mid-count beats a simultaneous write
      drive(0, 1, 1, 4);
      drive(0, 1, 0, 32'hB);
      for (int i = 1; i <= 3; i++) drive(0, 0, 0, 0);
      drive(1, 1, 0, 32'hB);
      $display("txn reset during count");
      rd(0, v); chk("midreset_ctrl", v, 32'd0);
      rd(2, v); chk("midreset_count", v, 32'd0);
      chk("midreset_irq", {31'd0, irq}, 32'd0);

      // random traffic
      for (int c = 0; c < 2000; c++) begin
         logic r, w;
         logic [1:0] a;
         r = ($urandom_range(0, 299) == 0);
         w = ($urandom_range(0, 11) == 0);
         a = 2'($urandom_range(0, 3));
         d = $urandom;
         if (a == 2'd0) begin
            d[15:8] = 8'($urandom_range(0, 3));
            d[0] = ($urandom_range(0, 3) != 0);
         end else if ($urandom_range(0, 15) != 0) begin
            d = $urandom_range(0, 7);
         end
         if (w || r) $display("txn rst=%0d we=%0d addr=%0d din=0x%08h", r, w, a, d);
         drive(r, w, a, d);
      end

      @(negedge clk);
      cmp_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
